x_mux_sweep_ctrl: RTL

- Sequencer for the x_mux_trigger delay line.
- Steps the 32-bit mux select code (i_data of the delay line) from a first to a last value.
- At each code: settles, fires a trigger pulse, samples the returned (already synchronised) driver level, then reports {code, hit} over a valid/ready result port.
- Sits between the host/UART command logic and the delay-line instance. Used for delay calibration sweeps.

---
 rtl/x_mux_sweep_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/x_mux_sweep_ctrl.sv
// rtl/x_mux_sweep_ctrl.sv - select-code sweep sequencer for the x_mux_trigger delay line
// Optional abort input enabled by defining X_MUX_SWEEP_ABORT_EN.
module x_mux_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int FIRE_CYCLES   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_first,
  input  logic [31:0] i_last,
  input  logic [31:0] i_step,
  input  logic        i_sample,
  output logic [31:0] o_data,
  output logic        o_trigger,
  output logic        o_busy,
  output logic        o_result_valid,
  input  logic        i_result_ready,
  output logic [31:0] o_result_code,
  output logic        o_result_hit,
  output logic        o_done
`ifdef X_MUX_SWEEP_ABORT_EN
  ,
  input  logic        i_abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_FIRE, S_RELEASE, S_REPORT, S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] FIRE_LAST   = 8'(FIRE_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_last;
  logic [31:0] r_step;
  logic        r_hit;

  logic [32:0] w_sum;
  logic        w_final;
  logic        w_abort;

  // o_data doubles as the current code; a carry out means the next code wrapped.
  assign w_sum   = {1'b0, o_data} + {1'b0, r_step};
  assign w_final = (o_data == r_last) || w_sum[32] || (w_sum[31:0] > r_last);

`ifdef X_MUX_SWEEP_ABORT_EN
  assign w_abort = i_abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_last         <= 32'd0;
      r_step         <= 32'd0;
      r_hit          <= 1'b0;
      o_data         <= 32'd0;
      o_trigger      <= 1'b0;
      o_busy         <= 1'b0;
      o_result_valid <= 1'b0;
      o_result_code  <= 32'd0;
      o_result_hit   <= 1'b0;
      o_done         <= 1'b0;
    end else if (w_abort) begin
      r_state        <= S_DONE;
      r_cnt          <= 8'd0;
      o_trigger      <= 1'b0;
      o_result_valid <= 1'b0;
      o_done         <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_last  <= i_last;
            r_step  <= (i_step == 32'd0) ? 32'd1 : i_step;
            o_data  <= i_first;
            o_busy  <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt     <= 8'd0;
            o_trigger <= 1'b1;
            r_state   <= S_FIRE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FIRE: begin
          if (r_cnt == FIRE_LAST) begin
            r_cnt     <= 8'd0;
            r_hit     <= i_sample;
            o_trigger <= 1'b0;
            r_state   <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt          <= 8'd0;
            o_result_valid <= 1'b1;
            o_result_code  <= o_data;
            o_result_hit   <= r_hit;
            r_state        <= S_REPORT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_REPORT: begin
          if (i_result_ready) begin
            o_result_valid <= 1'b0;
            if (w_final) begin
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_data  <= w_sum[31:0];
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
